// File: rtl/pong_pkg.sv
// Shared Pong geometry: screen, paddle and ball sizes plus derived
// position widths used by the game engine, pixel engine and hit detector.
package pong_pkg;

   localparam int WIDTH        = 640;
   localparam int HEIGHT       = 480;
   localparam int PLAYER_LEN   = 64;
   localparam int PLAYER_WID   = 8;
   localparam int BALL_PIXSIZE = 8;

   // Bits needed for a top/left edge that keeps an object fully on screen
   function automatic int pos_w(input int span, input int size);
      return $clog2(span - size);
   endfunction

   localparam int PLAYER_HEIGHT_LOG = pos_w(HEIGHT, PLAYER_LEN);
   localparam int BALL_HEIGHT_LOG   = pos_w(HEIGHT, BALL_PIXSIZE);
   localparam int BALL_WIDTH_LOG    = pos_w(WIDTH, BALL_PIXSIZE);

endpackage

// File: rtl/pong_span_delay.sv
// Tests lo <= v < lo+SIZE without wrap-around, qualifies it, and delays
// the result through STAGES enable-gated, reset-clearable registers.
module pong_span_delay
   import pong_pkg::*;
#(
   parameter int LO_W   = 10,
   parameter int V_W    = 10,
   parameter int SIZE   = 8,
   parameter int STAGES = 0
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [LO_W-1:0] i_lo,
   input  logic [V_W-1:0]  i_v,
   input  logic            i_en,
   input  logic            i_qual,
   output logic            o_hit
);

   localparam int W = ((LO_W > V_W) ? LO_W : V_W) + 1;

   logic [W-1:0] w_lo;
   logic [W-1:0] w_v;
   logic [W-1:0] w_hi;
   logic         w_match;

   assign w_lo    = W'(i_lo);
   assign w_v     = W'(i_v);
   assign w_hi    = w_lo + W'(SIZE);
   assign w_match = i_qual && (w_v >= w_lo) && (w_v < w_hi);

   generate
      if (STAGES == 0) begin : g_comb
         assign o_hit = w_match;
      end else begin : g_pipe
         logic [STAGES-1:0] r_pipe;

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               r_pipe <= '0;
            end else if (i_en) begin
               r_pipe[0] <= w_match;
               for (int i = 1; i < STAGES; i++) begin
                  r_pipe[i] <= r_pipe[i-1];
               end
            end
         end

         assign o_hit = r_pipe[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/pong_object_hit_detector.sv
// Per-pixel paddle/ball hit flags: vertical ranges latched in blanking,
// horizontal spans matched per pixel and pipelined to the colour mux.
module pong_object_hit_detector
   import pong_pkg::*;
#(
   parameter int WIDTH           = pong_pkg::WIDTH,
   parameter int HEIGHT          = pong_pkg::HEIGHT,
   parameter int H_CNT_WID       = 10,
   parameter int V_CNT_WID       = 10,
   parameter int PIPELINE_STAGES = 1,
   parameter int BALL_PIXSIZE    = pong_pkg::BALL_PIXSIZE,
   parameter int PLAYER_LEN      = pong_pkg::PLAYER_LEN,
   parameter int PLAYER_WID      = pong_pkg::PLAYER_WID,
   localparam int PLAYER_HEIGHT_LOG = pos_w(HEIGHT, PLAYER_LEN),
   localparam int BALL_HEIGHT_LOG   = pos_w(HEIGHT, BALL_PIXSIZE),
   localparam int BALL_WIDTH_LOG    = pos_w(WIDTH, BALL_PIXSIZE)
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         H_BLANK,
   input  logic [V_CNT_WID-1:0]         nextY,
   input  logic [H_CNT_WID-1:0]         drawX,
   input  logic [BALL_WIDTH_LOG-1:0]    ballXPos,
   input  logic [BALL_HEIGHT_LOG-1:0]   ballYPos,
   input  logic [PLAYER_HEIGHT_LOG-1:0] player1Pos,
   input  logic [PLAYER_HEIGHT_LOG-1:0] player2Pos,
   output logic                         isPlayer1,
   output logic                         isPlayer2,
   output logic                         isBall
);

   localparam logic [H_CNT_WID-1:0] P2_LEFT = H_CNT_WID'(WIDTH - PLAYER_WID);

   logic w_p1_y;
   logic w_p2_y;
   logic w_ball_y;

   // Vertical flags: one register each, reloaded only during blanking
   pong_span_delay #(
      .LO_W(PLAYER_HEIGHT_LOG), .V_W(V_CNT_WID),
      .SIZE(PLAYER_LEN), .STAGES(1)
   ) u_p1_y (
      .CLK(CLK), .RST(RST), .i_lo(player1Pos), .i_v(nextY),
      .i_en(H_BLANK), .i_qual(1'b1), .o_hit(w_p1_y)
   );

   pong_span_delay #(
      .LO_W(PLAYER_HEIGHT_LOG), .V_W(V_CNT_WID),
      .SIZE(PLAYER_LEN), .STAGES(1)
   ) u_p2_y (
      .CLK(CLK), .RST(RST), .i_lo(player2Pos), .i_v(nextY),
      .i_en(H_BLANK), .i_qual(1'b1), .o_hit(w_p2_y)
   );

   pong_span_delay #(
      .LO_W(BALL_HEIGHT_LOG), .V_W(V_CNT_WID),
      .SIZE(BALL_PIXSIZE), .STAGES(1)
   ) u_ball_y (
      .CLK(CLK), .RST(RST), .i_lo(ballYPos), .i_v(nextY),
      .i_en(H_BLANK), .i_qual(1'b1), .o_hit(w_ball_y)
   );

   pong_span_delay #(
      .LO_W(H_CNT_WID), .V_W(H_CNT_WID),
      .SIZE(PLAYER_WID), .STAGES(PIPELINE_STAGES)
   ) u_p1_x (
      .CLK(CLK), .RST(RST), .i_lo('0), .i_v(drawX),
      .i_en(1'b1), .i_qual(w_p1_y), .o_hit(isPlayer1)
   );

   pong_span_delay #(
      .LO_W(H_CNT_WID), .V_W(H_CNT_WID),
      .SIZE(PLAYER_WID), .STAGES(PIPELINE_STAGES)
   ) u_p2_x (
      .CLK(CLK), .RST(RST), .i_lo(P2_LEFT), .i_v(drawX),
      .i_en(1'b1), .i_qual(w_p2_y), .o_hit(isPlayer2)
   );

   pong_span_delay #(
      .LO_W(BALL_WIDTH_LOG), .V_W(H_CNT_WID),
      .SIZE(BALL_PIXSIZE), .STAGES(PIPELINE_STAGES)
   ) u_ball_x (
      .CLK(CLK), .RST(RST), .i_lo(ballXPos), .i_v(drawX),
      .i_en(1'b1), .i_qual(w_ball_y), .o_hit(isBall)
   );

endmodule

// File: tb/tb_pong_object_hit_detector.sv
// Directed bench for the hit detector: a one-stage pipelined instance
// and a combinational instance driven by the same stimulus.
module tb_pong_object_hit_detector;
   import pong_pkg::*;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       H_BLANK = 1'b0;
   logic [9:0] nextY = '0;
   logic [9:0] drawX = '0;
   logic [9:0] ballXPos = '0;
   logic [8:0] ballYPos = '0;
   logic [8:0] player1Pos = '0;
   logic [8:0] player2Pos = '0;

   logic p1_q, p2_q, ball_q;
   logic p1_c, p2_c, ball_c;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   pong_object_hit_detector #(.PIPELINE_STAGES(1)) u_dut_q (
      .CLK(CLK), .RST(RST), .H_BLANK(H_BLANK),
      .nextY(nextY), .drawX(drawX),
      .ballXPos(ballXPos), .ballYPos(ballYPos),
      .player1Pos(player1Pos), .player2Pos(player2Pos),
      .isPlayer1(p1_q), .isPlayer2(p2_q), .isBall(ball_q)
   );

   pong_object_hit_detector #(.PIPELINE_STAGES(0)) u_dut_c (
      .CLK(CLK), .RST(RST), .H_BLANK(H_BLANK),
      .nextY(nextY), .drawX(drawX),
      .ballXPos(ballXPos), .ballYPos(ballYPos),
      .player1Pos(player1Pos), .player2Pos(player2Pos),
      .isPlayer1(p1_c), .isPlayer2(p2_c), .isBall(ball_c)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One blanking cycle that loads the vertical flags for line y
   task automatic latch_y(input int y);
      @(negedge CLK);
      H_BLANK = 1'b1;
      nextY = 10'(y);
      @(negedge CLK);
      H_BLANK = 1'b0;
   endtask

   // Comb instance checked in the same cycle, piped one cycle later
   task automatic pix(input string tag, input int x,
                      input bit e1, input bit e2, input bit eb);
      @(negedge CLK);
      drawX = 10'(x);
      #1;
      chk({tag, "/c_p1"}, p1_c, e1);
      chk({tag, "/c_p2"}, p2_c, e2);
      chk({tag, "/c_ball"}, ball_c, eb);
      @(posedge CLK);
      #1;
      chk({tag, "/q_p1"}, p1_q, e1);
      chk({tag, "/q_p2"}, p2_q, e2);
      chk({tag, "/q_ball"}, ball_q, eb);
   endtask

   initial begin
      player1Pos = 9'd100;
      player2Pos = 9'd0;
      ballXPos   = 10'd300;
      ballYPos   = 9'd200;
      H_BLANK    = 1'b1;
      nextY      = 10'd100;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_p1", p1_q, 0);
      chk("rst_p2", p2_q, 0);
      chk("rst_ball", ball_q, 0);
      chk("rst_c_p1", p1_c, 0);
      @(negedge CLK);
      RST = 1'b0;
      H_BLANK = 1'b0;

      latch_y(100);
      for (int x = 0; x < 10; x++)
         pix($sformatf("left_x%0d", x), x, x < 8, 1'b0, 1'b0);

      latch_y(99);
      pix("y99", 0, 1'b0, 1'b0, 1'b0);
      latch_y(163);
      pix("y163", 0, 1'b1, 1'b0, 1'b0);
      latch_y(164);
      pix("y164", 0, 1'b0, 1'b0, 1'b0);

      latch_y(0);
      pix("right_631", 631, 1'b0, 1'b0, 1'b0);
      for (int x = 632; x < 640; x++)
         pix($sformatf("right_x%0d", x), x, 1'b0, 1'b1, 1'b0);
      pix("right_640", 640, 1'b0, 1'b0, 1'b0);
      pix("right_p1", 5, 1'b0, 1'b0, 1'b0);

      latch_y(207);
      for (int x = 299; x < 309; x++)
         pix($sformatf("ball_x%0d", x), x, 1'b0, 1'b0,
             (x >= 300) && (x < 308));
      latch_y(208);
      for (int x = 299; x < 309; x++)
         pix($sformatf("noball_x%0d", x), x, 1'b0, 1'b0, 1'b0);

      latch_y(100);
      @(negedge CLK);
      nextY = 10'd300;
      pix("hold", 0, 1'b1, 1'b0, 1'b0);

      // Async reset mid-line while isPlayer1 is high
      @(negedge CLK);
      #2;
      RST = 1'b1;
      #1;
      chk("arst_p1", p1_q, 0);
      chk("arst_c_p1", p1_c, 0);
      chk("arst_p2", p2_q, 0);
      chk("arst_ball", ball_q, 0);
      @(negedge CLK);
      RST = 1'b0;
      nextY = 10'd100;
      pix("post_rst", 0, 1'b0, 1'b0, 1'b0);
      latch_y(100);
      pix("reload", 0, 1'b1, 1'b0, 1'b0);

      // Overlap: ball over left paddle
      ballXPos = 10'd4;
      ballYPos = 9'd100;
      latch_y(100);
      pix("overlap", 5, 1'b1, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
